if_id_buffer: RTL and testbench
===============================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the number of buffered fetch entries; legal values are powers of two, at least 2.
REQ-002 Parameter NOP, default 32'b0, SHALL be the instruction word driven on id_instr when no entry is valid.
REQ-003 Port clk, input, 1 bit: SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: SHALL be an asynchronous, active-high reset.
REQ-005 Port if_valid, input, 1 bit: fetch offers an entry this cycle.
REQ-006 Port if_pc, input, 32 bits: word-addressed PC of the offered instruction.
REQ-007 Port im_dataout, input, 32 bits: instruction word read from instruction memory for if_pc.
REQ-008 Port if_ready, output, 1 bit: the buffer can accept an entry; the fetch stage holds its PC while this is low.
REQ-009 Port flush, input, 1 bit: branch/jump redirect; discard all buffered and offered entries.
REQ-010 Port id_valid, output, 1 bit: id_pc/id_instr hold a valid entry.
REQ-011 Port id_pc, output, 32 bits: PC of the head entry.
REQ-012 Port id_instr, output, 32 bits: instruction of the head entry.
REQ-013 Port id_ready, input, 1 bit: decode consumes the head entry this cycle.
REQ-014 Port stall_cnt, output, 16 bits: saturating count of back-pressure cycles.

Function
REQ-015 Storage: DEPTH entries of {pc[31:0], instr[31:0]}, circular, with a read pointer and a write pointer of log2(DEPTH) bits and count of log2(DEPTH)+1 bits.
REQ-016 if_ready SHALL equal (count != DEPTH), from registered state only, with no combinational path from id_ready or if_valid.
REQ-017 push = if_valid & if_ready & ~flush; on push, {if_pc, im_dataout} SHALL be written at the write pointer, and the write pointer SHALL advance modulo DEPTH.
REQ-018 id_valid SHALL equal (count != 0); when 1, id_pc/id_instr SHALL show the entry at the read pointer; when 0, id_pc = 32'b0 and id_instr = NOP.
REQ-019 pop = id_valid & id_ready & ~flush; on pop, the read pointer SHALL advance modulo DEPTH.
REQ-020 Count update: push only +1; pop only -1; push and pop together unchanged; the buffer never exceeds DEPTH and never underflows.
REQ-021 Latency: an entry pushed in cycle N SHALL be visible on id_* no earlier than cycle N+1; there is no same-cycle bypass.
REQ-022 Full with a simultaneous pop: the push SHALL be refused because if_ready is already 0; acceptance resumes in the following cycle.
REQ-023 Order: entries SHALL leave in exactly the order accepted, with no duplication or loss except on flush.
REQ-024 Flush has priority over push and pop: count and both pointers SHALL be reset to 0, the offered entry SHALL be dropped, id_valid SHALL be 0 and if_ready SHALL be 1 from the next cycle.
REQ-025 Flush while empty SHALL be harmless and leave the state unchanged.
REQ-026 stall_cnt SHALL increment by 1 in each cycle with if_valid & ~if_ready & ~flush, SHALL saturate at 16'hFFFF, and SHALL be cleared only by reset.

Reset
REQ-027 While rst = 1, asynchronously: count = 0, pointers = 0, stall_cnt = 0, id_valid = 0, id_pc = 0, id_instr = NOP, if_ready = 1.
REQ-028 Reset asserted mid-transfer SHALL discard all entries; the first push after rst deasserts SHALL be the first entry presented.
REQ-029 Storage contents need no reset; they SHALL never be observable while id_valid = 0.

Verification
REQ-030 Streaming: id_ready = 1, push pc 0..7 with instr 0xA0+pc on consecutive cycles -> id_pc 0..7 in order, one cycle behind each push; if_ready stays 1; stall_cnt = 0.
REQ-031 Fill (DEPTH = 2): id_ready = 0, push pc 4, 5, 6 -> if_ready = 0 after the second push; pc 6 is not accepted; stall_cnt = 1 per held cycle.
REQ-032 Drain while full: hold pc 6 offered, set id_ready = 1 -> output pc 4, then 5, then 6; if_ready returns to 1 the cycle after the first pop.
REQ-033 Flush: two entries buffered, flush = 1 with if_valid = 1, pc 9 -> next cycle id_valid = 0, id_instr = NOP, count = 0; pc 9 is never output.
REQ-034 Saturation: force 70000 stalled cycles -> stall_cnt = 16'hFFFF and holds.
REQ-035 Async reset: assert rst between clock edges with 1 entry buffered -> id_valid = 0 and if_ready = 1 immediately, before the next edge.

Source files
------------

// File: rtl/if_id_if.sv
// Fetch-to-decode handshake bundle for the IF/ID buffer.
interface if_id_if;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] im_dataout;
    logic        if_ready;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready;
    logic [15:0] stall_cnt;

    // Buffer side
    modport slave (
        input  if_valid, if_pc, im_dataout, flush, id_ready,
        output if_ready, id_valid, id_pc, id_instr, stall_cnt
    );

    // Fetch/decode (environment) side
    modport master (
        output if_valid, if_pc, im_dataout, flush, id_ready,
        input  if_ready, id_valid, id_pc, id_instr, stall_cnt
    );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: circular FIFO of {pc, instr} between fetch and decode,
// with flush and a saturating back-pressure counter.
module if_id_buffer #(
    parameter int unsigned DEPTH = 2,
    parameter logic [31:0] NOP   = 32'b0
) (
    input  logic    clk,
    input  logic    rst,
    if_id_if.slave  bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [63:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_id_valid;
    logic             r_if_ready;
    logic [15:0]      r_stall_cnt;

    logic             w_push;
    logic             w_pop;
    logic             w_stall;
    logic [CNT_W-1:0] w_count_nxt;

    // Handshake qualifiers use only registered readiness, so no input-to-ready path exists
    assign w_push  = bus.if_valid & r_if_ready & ~bus.flush;
    assign w_pop   = r_id_valid & bus.id_ready & ~bus.flush;
    assign w_stall = bus.if_valid & ~r_if_ready & ~bus.flush;

    // Next occupancy: flush wins, otherwise +1 / -1 / hold
    always_comb begin
        w_count_nxt = r_count;
        if (bus.flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Pointers, occupancy and the registered valid/ready flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_id_valid <= 1'b0;
            r_if_ready <= 1'b1;
        end else begin
            r_count    <= w_count_nxt;
            r_id_valid <= (w_count_nxt != '0);
            r_if_ready <= (w_count_nxt != CNT_W'(DEPTH));
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Entry storage; contents are masked by id_valid so they need no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.if_pc, bus.im_dataout};
        end
    end

    // Saturating count of cycles where fetch was held off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.if_ready  = r_if_ready;
    assign bus.id_valid  = r_id_valid;
    assign bus.id_pc     = r_id_valid ? r_mem[r_rd_ptr][63:32] : 32'b0;
    assign bus.id_instr  = r_id_valid ? r_mem[r_rd_ptr][31:0]  : NOP;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer against a queue-based reference model.
module tb_if_id_buffer;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk;
    logic rst;
    if_id_if bus();

    if_id_buffer #(.DEPTH(DEPTH), .NOP(NOP)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: ordered list of accepted entries plus stall counter
    logic [63:0] m_q[$];
    int unsigned m_stall;

    int unsigned n_cmp;
    int unsigned n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        e_valid = (m_q.size() != 0);
        e_ready = (m_q.size() != DEPTH);
        e_pc    = e_valid ? m_q[0][63:32] : 32'b0;
        e_instr = e_valid ? m_q[0][31:0]  : NOP;
        check({tag, ".id_valid"},  64'(bus.id_valid),  64'(e_valid));
        check({tag, ".if_ready"},  64'(bus.if_ready),  64'(e_ready));
        check({tag, ".id_pc"},     64'(bus.id_pc),     64'(e_pc));
        check({tag, ".id_instr"},  64'(bus.id_instr),  64'(e_instr));
        check({tag, ".stall_cnt"}, 64'(bus.stall_cnt), 64'(m_stall));
    endtask

    // One clock: decide accept/consume from the pre-edge model, advance, then compare
    task automatic cycle(input string tag);
        bit full;
        bit empty;
        bit push;
        bit pop;
        full  = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        push  = bus.if_valid && !full && !bus.flush;
        pop   = !empty && bus.id_ready && !bus.flush;
        if (bus.if_valid && full && !bus.flush && m_stall < 65535) m_stall++;
        @(posedge clk);
        if (bus.flush) begin
            m_q.delete();
        end else begin
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back({bus.if_pc, bus.im_dataout});
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        bus.if_valid   = v;
        bus.if_pc      = pc;
        bus.im_dataout = 32'hA0 + pc;
        bus.id_ready   = rdy;
        bus.flush      = fl;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        m_q.delete();
        m_stall = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs("reset");
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        do_reset();

        // Streaming: each push appears on id_* one cycle later, in order
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i), 1'b1, 1'b0);
            cycle("stream");
            check("stream.pc_order", 64'(bus.id_pc), 64'(i));
            check("stream.instr", 64'(bus.id_instr), 64'(32'hA0 + i));
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        cycle("stream_tail");
        check("stream.stall_zero", 64'(bus.stall_cnt), 64'd0);

        // Fill to DEPTH with decode stalled, then hold pc 6 offered
        do_reset();
        drive(1'b1, 32'd4, 1'b0, 1'b0);  cycle("fill4");
        check("fill.ready_after_1", 64'(bus.if_ready), 64'd1);
        drive(1'b1, 32'd5, 1'b0, 1'b0);  cycle("fill5");
        check("fill.ready_after_2", 64'(bus.if_ready), 64'd0);
        drive(1'b1, 32'd6, 1'b0, 1'b0);  cycle("fill6a");
        check("fill.stall_1", 64'(bus.stall_cnt), 64'd1);
        cycle("fill6b");
        check("fill.stall_2", 64'(bus.stall_cnt), 64'd2);
        check("fill.head_still_4", 64'(bus.id_pc), 64'd4);

        // Drain while full: pop 4 (push refused), then 6 enters behind 5
        drive(1'b1, 32'd6, 1'b1, 1'b0);  cycle("drain1");
        check("drain.head_5", 64'(bus.id_pc), 64'd5);
        check("drain.ready_back", 64'(bus.if_ready), 64'd1);
        cycle("drain2");
        check("drain.head_6", 64'(bus.id_pc), 64'd6);
        drive(1'b0, 32'd0, 1'b1, 1'b0);  cycle("drain3");
        check("drain.empty", 64'(bus.id_valid), 64'd0);

        // Flush with two buffered entries and pc 9 offered
        do_reset();
        drive(1'b1, 32'd1, 1'b0, 1'b0);  cycle("pre_flush1");
        drive(1'b1, 32'd2, 1'b0, 1'b0);  cycle("pre_flush2");
        drive(1'b1, 32'd9, 1'b1, 1'b1);  cycle("flush");
        check("flush.valid", 64'(bus.id_valid), 64'd0);
        check("flush.nop", 64'(bus.id_instr), 64'(NOP));
        check("flush.ready", 64'(bus.if_ready), 64'd1);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("post_flush");
            check("flush.pc9_dropped", 64'(bus.id_valid), 64'd0);
        end
        drive(1'b0, 32'd0, 1'b1, 1'b1);  cycle("flush_empty");
        drive(1'b1, 32'd3, 1'b0, 1'b0);  cycle("after_flush_push");
        check("flush.next_push_pc", 64'(bus.id_pc), 64'd3);

        // Randomised traffic, including occasional flushes
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 31) == 0));
            bus.im_dataout = $urandom;
            cycle("rand");
        end

        // Async reset between edges with one entry buffered
        do_reset();
        drive(1'b1, 32'd42, 1'b0, 1'b0);  cycle("ar_push");
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("areset.valid", 64'(bus.id_valid), 64'd0);
        check("areset.ready", 64'(bus.if_ready), 64'd1);
        check("areset.pc", 64'(bus.id_pc), 64'd0);
        check("areset.instr", 64'(bus.id_instr), 64'(NOP));
        m_q.delete();
        m_stall = 0;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'd77, 1'b1, 1'b0);  cycle("ar_first");
        check("areset.first_entry", 64'(bus.id_pc), 64'd77);

        // Saturation: 70000 held cycles
        do_reset();
        drive(1'b1, 32'd100, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) begin
            bus.if_pc = $urandom;
            cycle("sat");
        end
        check("sat.ffff", 64'(bus.stall_cnt), 64'hFFFF);
        repeat (4) cycle("sat_hold");
        check("sat.holds", 64'(bus.stall_cnt), 64'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
